// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between two requesters, one access in flight.
// Optional BUSY-timeout abort is enabled by defining DMEM_ARB_TIMEOUT_EN.
module dmem_port_arbiter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              r0_read_i,
    input  logic              r0_write_i,
    input  logic [ADDR_W-1:0] r0_addr_i,
    input  logic [DATA_W-1:0] r0_data_i,
    output logic              r0_done_o,
    output logic [DATA_W-1:0] r0_rd_data_o,
    input  logic              r1_read_i,
    input  logic              r1_write_i,
    input  logic [ADDR_W-1:0] r1_addr_i,
    input  logic [DATA_W-1:0] r1_data_i,
    output logic              r1_done_o,
    output logic [DATA_W-1:0] r1_rd_data_o,
    input  logic [DATA_W-1:0] dmem_rd_data_i,
    input  logic              dmem_done_i,
    output logic              dmem_read_o,
    output logic              dmem_write_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_data_o,
    output logic              busy_o,
    output logic              grant_o,
    output logic              timeout_o
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_q, grant_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              r0_valid, r1_valid, pick, expire;

    assign r0_valid = r0_read_i | r0_write_i;
    assign r1_valid = r1_read_i | r1_write_i;
    // On a tie the requester that was not served last wins.
    assign pick     = (r0_valid & r1_valid) ? ~last_grant_q : ~r0_valid;

`ifdef DMEM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;

    assign expire = (state_q == ST_BUSY) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counter is zero whenever BUSY is entered; a done on the expiry cycle suppresses the abort flag.
    always_comb begin
        cnt_d = '0;
        to_d  = 1'b0;
        if (state_q == ST_BUSY) begin
            cnt_d = cnt_q + CNT_W'(1);
            to_d  = expire & ~dmem_done_i;
        end else if (state_q == ST_RESP) begin
            to_d = to_q;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign timeout_o = (state_q == ST_RESP) & to_q;
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;

    assign expire    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        data_d       = data_q;
        rdata_d      = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (r0_valid | r1_valid) begin
                    grant_d = pick;
                    state_d = ST_BUSY;
                    if (!pick) begin
                        wr_d   = r0_write_i;
                        rd_d   = r0_read_i & ~r0_write_i;
                        addr_d = r0_addr_i;
                        data_d = r0_data_i;
                    end else begin
                        wr_d   = r1_write_i;
                        rd_d   = r1_read_i & ~r1_write_i;
                        addr_d = r1_addr_i;
                        data_d = r1_data_i;
                    end
                end
            end
            ST_BUSY: begin
                if (dmem_done_i || expire) begin
                    rdata_d      = (dmem_done_i && rd_q) ? dmem_rd_data_i : '0;
                    rd_d         = 1'b0;
                    wr_d         = 1'b0;
                    last_grant_d = grant_q;
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            rdata_q      <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            rdata_q      <= rdata_d;
        end
    end

    always_comb begin
        r0_done_o    = 1'b0;
        r1_done_o    = 1'b0;
        r0_rd_data_o = '0;
        r1_rd_data_o = '0;
        busy_o       = (state_q != ST_IDLE);
        if (state_q == ST_RESP) begin
            if (grant_q) begin
                r1_done_o    = 1'b1;
                r1_rd_data_o = rdata_q;
            end else begin
                r0_done_o    = 1'b1;
                r0_rd_data_o = rdata_q;
            end
        end
    end

    assign dmem_read_o  = rd_q;
    assign dmem_write_o = wr_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_data_o  = data_q;
    assign grant_o      = grant_q;

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between two requesters: requester 0 (the load/store unit's memory read/write path) and requester 1 (a secondary data-memory client, e.g. a debug/DMA port).
- Round-robin arbitration with one outstanding access at a time.
- Memory-side outputs are registered and held until the memory's done handshake; a one-cycle done pulse with read data returns to the granted requester.
- Sits between the load/store unit and the data memory.

Parameters:
- ADDR_W, 32, width of address buses.
- DATA_W, 32, width of data buses (word32_t).
- TIMEOUT_CYCLES, 64, max BUSY cycles before abort (used only with the optional feature).

Ports:
- clk_i  in  1  clock; single clock domain.
- reset_ni  in  1  asynchronous, active-low reset.
- r0_read_i  in  1  requester 0 read request; held until r0_done_o.
- r0_write_i  in  1  requester 0 write request; held until r0_done_o.
- r0_addr_i  in  ADDR_W  requester 0 address.
- r0_data_i  in  DATA_W  requester 0 write data.
- r0_done_o  out  1  one-cycle completion pulse to requester 0.
- r0_rd_data_o  out  DATA_W  read data, valid while r0_done_o is high.
- r1_read_i, r1_write_i, r1_addr_i, r1_data_i, r1_done_o, r1_rd_data_o: same as requester 0, for requester 1.
- dmem_rd_data_i  in  DATA_W  memory read data, valid with dmem_done_i.
- dmem_done_i  in  1  memory completion.
- dmem_read_o  out  1  memory read strobe, held through the access.
- dmem_write_o  out  1  memory write strobe, held through the access.
- dmem_addr_o  out  ADDR_W  memory address.
- dmem_data_o  out  DATA_W  memory write data.
- busy_o  out  1  high in BUSY or RESP.
- grant_o  out  1  index of the current or last granted requester.
- timeout_o  out  1  pulses with done_o when an access aborts (feature only; otherwise tied 0).

Behaviour:
- Reset (asynchronous, reset_ni=0):
  - state=IDLE; all outputs 0.
  - last_grant=1, so requester 0 wins the first tie.
  - Internal address, data and read-data registers cleared.
  - Reset asserted mid-access drops dmem strobes immediately; any in-flight access is abandoned with no done pulse.
- Request valid = read|write. If both are high, the access is a write and read is ignored.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If exactly one requester is valid, grant it.
  - If both are valid, grant the one not equal to last_grant.
  - On grant: latch op, addr and data into output registers; set grant_o; go to BUSY next edge.
  - dmem strobes rise on the cycle after the request is first seen (1-cycle issue latency).
- BUSY:
  - dmem_read_o/dmem_write_o, dmem_addr_o and dmem_data_o are held constant.
  - Requester inputs are not resampled; changes are ignored.
  - When dmem_done_i=1: capture dmem_rd_data_i (zero for writes), drop strobes on the next edge, go to RESP, update last_grant.
- RESP (exactly 1 cycle):
  - Granted requester's done_o=1 and rd_data_o=captured data; the other requester's done_o=0.
  - Requests are ignored this cycle, since the granted requester still shows its request.
  - Return to IDLE.
- Turnaround:
  - Minimum request-to-done is 3 cycles when memory returns done the first BUSY cycle.
  - Back-to-back grants are at minimum 3 cycles apart (IDLE, BUSY, RESP).
- dmem_done_i outside BUSY is ignored and has no state effect.
- Fairness:
  - With both requesters continuously valid, grants strictly alternate 0,1,0,1.
  - A requester that is alone is served every access without waiting.
- rd_data_o of the non-granted requester is 0.
- No address/data width arithmetic; all fields pass through unchanged.

Optional Feature:
- Macro: DMEM_ARB_TIMEOUT_EN.
- Defined:
  - Counter counts BUSY cycles from 0.
  - If it reaches TIMEOUT_CYCLES-1 without dmem_done_i: abort, drop strobes, go to RESP with rd_data 0.
  - done_o and timeout_o pulse together for 1 cycle.
  - Counter clears on entering BUSY.
  - dmem_done_i in the same cycle as expiry wins; no timeout is reported.
- Undefined: no counter logic; BUSY waits indefinitely; timeout_o tied 0.

Test Plan:
- Reset release, r0 read addr 0x100, memory done after 2 cycles with data 0xDEADBEEF -> dmem_read_o=1, dmem_addr_o=0x100 for 2 cycles; r0_done_o pulses once with r0_rd_data_o=0xDEADBEEF; r1_done_o stays 0.
- r0 and r1 both request in the same cycle after reset (r0 write 0x20/0x11, r1 read 0x40) -> r0 granted first (dmem_write_o, data 0x11), then r1 (dmem_read_o addr 0x40); grant_o goes 0 then 1.
- Both requesters hold requests continuously for 6 accesses, memory done in 1 cycle -> grant order 0,1,0,1,0,1; each done pulse 3 cycles apart.
- r1 asserts read_i and write_i together with data 0x55 -> only dmem_write_o=1; r1_rd_data_o=0 on done.
- reset_ni dropped during BUSY, mid-access -> dmem_read_o=0 in the same cycle (asynchronous); no done pulse; after release an r0 request is granted normally.
- With DMEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, memory never responds -> strobes drop after 8 BUSY cycles; r0_done_o=1 and timeout_o=1 for 1 cycle; rd_data 0.
